pdi_block_loader: RTL and testbench
===================================

# pdi_block_loader

- Serial-in/parallel-out loader for the LWC datapath.
- Accepts W-bit public-data words over a valid/ready handshake and assembles them into one N_WORDS×W cipher-state block.
- Applies 10* byte padding on the final, partial block and hands the block downstream over a valid/ready handshake.
- Sits directly upstream of the state register: blk drives its d input and the blk_valid & blk_ready handshake drives its en.

## Interface
Parameters:
- W, 32, word width in bits; multiple of 8.
- N_WORDS, 6, words per block; block width is W*N_WORDS (192 by default).
- PAD_BYTE, 8'h80, value inserted at the first unused byte position.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bdi  in  W  input word; byte 0 at bdi[W-1:W-8].
- bdi_valid_bytes  in  W/8  contiguous-from-MSB byte-valid mask (e.g. 4'b1100); not all-ones only with bdi_last.
- bdi_last  in  1  word is the final word of the message.
- bdi_valid  in  1  input word valid.
- bdi_ready  out  1  loader can accept a word.
- blk  out  W*N_WORDS  assembled block; word 0 at the MSBs.
- blk_last  out  1  block contains the final message word.
- blk_padded  out  1  a PAD_BYTE was inserted in this block.
- blk_valid  out  1  block valid.
- blk_ready  in  1  downstream accepts the block.

## Operation
- State machine: FILL and FULL; word counter cnt, range 0..N_WORDS-1.
- Input transfer: bdi_valid & bdi_ready in the same cycle.
- Output transfer: blk_valid & blk_ready in the same cycle.
- FILL:
  - bdi_ready=1, blk_valid=0.
  - On an input transfer, block word[cnt] <= bdi with invalid bytes forced to 0.
- Padding is applied only on the transfer with bdi_last=1:
  - Partial last word: the byte at the first 0 in bdi_valid_bytes becomes PAD_BYTE; blk_padded<=1.
  - Mask all-zero: byte 0 of word[cnt] = PAD_BYTE (empty-message or empty-tail case).
  - Mask all-ones and cnt<N_WORDS-1: word[cnt+1] <= {PAD_BYTE, zeros}; blk_padded<=1.
  - Mask all-ones and cnt=N_WORDS-1: no padding; blk_padded<=0.
  - All words above the pad position stay 0, because the block register is cleared on entry to FILL.
- FILL→FULL on a transfer where cnt=N_WORDS-1 or bdi_last=1.
  - blk_last <= bdi_last.
  - cnt <= 0.
- Otherwise cnt increments on each transfer.
- FULL:
  - bdi_ready=0, blk_valid=1.
  - blk, blk_last and blk_padded are held stable until the output transfer.
  - On the output transfer: →FILL, block register, blk_last and blk_padded cleared to 0.
- Message ending exactly on a block boundary with full words: the final block has blk_last=1, blk_padded=0.
  - The loader does not generate an extra pad-only block; that decision belongs to the controller.
- bdi_valid_bytes and bdi are ignored when bdi_valid=0 or bdi_ready=0.

## Timing
- Reset (async assert, sync release):
  - state=FILL, cnt=0, blk=0, blk_last=0, blk_padded=0.
  - blk_valid=0, bdi_ready=1 immediately on assertion.
- Latency: blk_valid rises in the cycle after the transfer of the final word of a block.
- No combinational path from blk_ready to bdi_ready; one bubble cycle between a block transfer and the next accepted word.
- Throughput: N_WORDS+1 cycles per block under continuous valid/ready.
- bdi_ready and blk_valid are decoded from the state register only (glitch-free, no input dependency).
- Reset mid-fill or while FULL discards the partial or held block; no output transfer is generated.
- Reset takes priority over every simultaneous event.

## Test plan
All scenarios use W=32, N_WORDS=6, PAD_BYTE=8'h80.
- Full block: words 0x00000001..0x00000006, last=0 on word 6, blk_ready=1.
  - Expect blk=0x000000010000000200000003000000040000000500000006, blk_last=0, blk_padded=0.
  - blk_valid asserted for exactly 1 cycle, in cycle 7.
- Partial last word: 0xAABBCCDD, then 0x11223344 with mask 4'b1100 and last=1.
  - Expect word1=0x11228000, words 2..5=0, blk_last=1, blk_padded=1.
- Full last word mid-block: 3 words ending with 0xDEADBEEF, mask 4'hF, last=1.
  - Expect word3=0x80000000, words 4..5=0, blk_padded=1.
- Empty message: single beat with mask 4'b0000, last=1.
  - Expect blk = 0x80 followed by 23 zero bytes, blk_last=1, blk_padded=1.
- Backpressure: hold blk_ready=0 for 10 cycles after a block completes.
  - blk stable and bdi_ready=0 throughout.
  - Next word is accepted only in the cycle after blk_ready=1.
- Reset mid-fill: assert rst after 3 words accepted.
  - Outputs go to reset values asynchronously.
  - A following 6-word block appears alone with no residue from the discarded words.

Source files
------------

// File: rtl/pdi_block_loader_if.sv
// rtl/pdi_block_loader_if.sv - word-in / block-out handshake bundle for the PDI block loader
interface pdi_block_loader_if #(
    parameter int W       = 32,
    parameter int N_WORDS = 6
);
    logic [W-1:0]         bdi;
    logic [W/8-1:0]       bdi_valid_bytes;
    logic                 bdi_last;
    logic                 bdi_valid;
    logic                 bdi_ready;
    logic [W*N_WORDS-1:0] blk;
    logic                 blk_last;
    logic                 blk_padded;
    logic                 blk_valid;
    logic                 blk_ready;

    modport master (
        output bdi, bdi_valid_bytes, bdi_last, bdi_valid, blk_ready,
        input  bdi_ready, blk, blk_last, blk_padded, blk_valid
    );

    modport slave (
        input  bdi, bdi_valid_bytes, bdi_last, bdi_valid, blk_ready,
        output bdi_ready, blk, blk_last, blk_padded, blk_valid
    );
endinterface

// File: rtl/pdi_block_loader.sv
// rtl/pdi_block_loader.sv - assembles public-data words into a padded cipher-state block
module pdi_block_loader #(
    parameter int          W        = 32,
    parameter int          N_WORDS  = 6,
    parameter logic [7:0]  PAD_BYTE = 8'h80
) (
    input  logic           clk,
    input  logic           rst,
    pdi_block_loader_if.slave io
);
    localparam int NB = W / 8;
    localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic {FILL, FULL} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   nxt_idx;
    logic [W-1:0]    words [N_WORDS];
    logic [W-1:0]    word_in;
    logic            blk_last_q, blk_padded_q;
    logic            in_xfer, out_xfer, cnt_at_max, pad_here, pad_next;
    logic [W*N_WORDS-1:0] blk_bus;

    assign io.bdi_ready  = (state == FILL);
    assign io.blk_valid  = (state == FULL);
    assign io.blk_last   = blk_last_q;
    assign io.blk_padded = blk_padded_q;
    assign io.blk        = blk_bus;

    assign in_xfer    = io.bdi_valid & io.bdi_ready;
    assign out_xfer   = io.blk_valid & io.blk_ready;
    assign cnt_at_max = (cnt == CW'(N_WORDS - 1));
    assign nxt_idx    = cnt_at_max ? cnt : cnt + 1'b1;

    // Valid bytes are contiguous from the MSB, so their count is also the pad position.
    always_comb begin
        int nvalid;
        nvalid  = 0;
        word_in = '0;
        for (int b = 0; b < NB; b++) begin
            if (io.bdi_valid_bytes[NB-1-b]) begin
                word_in[W-1-8*b -: 8] = io.bdi[W-1-8*b -: 8];
                nvalid = nvalid + 1;
            end
        end
        pad_here = io.bdi_last && (nvalid < NB);
        pad_next = io.bdi_last && (nvalid == NB) && !cnt_at_max;
        if (pad_here) begin
            for (int b = 0; b < NB; b++) begin
                if (b == nvalid) word_in[W-1-8*b -: 8] = PAD_BYTE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (in_xfer && (cnt_at_max || io.bdi_last)) state_nxt = FULL;
            FULL: if (out_xfer) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Clearing the block on leaving FULL is what keeps words above the pad position zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_WORDS; i++) words[i] <= '0;
            cnt          <= '0;
            blk_last_q   <= 1'b0;
            blk_padded_q <= 1'b0;
        end else if (state == FILL) begin
            if (in_xfer) begin
                words[cnt] <= word_in;
                if (pad_next) words[nxt_idx] <= W'(PAD_BYTE) << (W - 8);
                blk_padded_q <= pad_here | pad_next;
                if (cnt_at_max || io.bdi_last) begin
                    cnt        <= '0;
                    blk_last_q <= io.bdi_last;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else if (out_xfer) begin
            for (int i = 0; i < N_WORDS; i++) words[i] <= '0;
            blk_last_q   <= 1'b0;
            blk_padded_q <= 1'b0;
        end
    end

    always_comb begin
        blk_bus = '0;
        for (int i = 0; i < N_WORDS; i++) blk_bus[W*N_WORDS-1-W*i -: W] = words[i];
    end
endmodule

// File: tb/tb_pdi_block_loader.sv
// tb/tb_pdi_block_loader.sv - directed and randomized bench for pdi_block_loader
module tb_pdi_block_loader;
    localparam int W  = 32;
    localparam int NW = 6;
    localparam int BB = W * NW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pdi_block_loader_if #(.W(W), .N_WORDS(NW)) io ();
    pdi_block_loader #(.W(W), .N_WORDS(NW), .PAD_BYTE(8'h80)) dut (.clk(clk), .rst(rst), .io(io));

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0]  msg [$];
    logic [BB-1:0] exp_blk [$];
    logic          exp_last [$];
    logic          exp_pad [$];
    logic [BB-1:0] last_blk;

    task automatic check(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: each block holds the valid bytes of its words; a final block shorter
    // than the full block width gets 0x80 appended, and the remainder is zero.
    task automatic build_model(input logic has_last, input logic [3:0] last_mask);
        exp_blk = {}; exp_last = {}; exp_pad = {};
        for (int s = 0; s < msg.size(); s += NW) begin
            logic [7:0]    bytes [$];
            logic [BB-1:0] v;
            logic          fin, pad;
            logic [3:0]    m;
            logic [W-1:0]  wd;
            fin = 1'b0;
            for (int k = s; k < s + NW && k < msg.size(); k++) begin
                m  = (has_last && k == msg.size() - 1) ? last_mask : 4'hF;
                wd = msg[k];
                for (int b = 0; b < 4; b++) if (m[3-b]) bytes.push_back(wd[31-8*b -: 8]);
                if (k == msg.size() - 1) fin = has_last;
            end
            pad = fin && (bytes.size() < BB / 8);
            if (pad) bytes.push_back(8'h80);
            v = '0;
            for (int i = 0; i < bytes.size(); i++) v[BB-1-8*i -: 8] = bytes[i];
            exp_blk.push_back(v);
            exp_last.push_back(fin);
            exp_pad.push_back(pad);
        end
    endtask

    task automatic idle_inputs();
        io.bdi = '0; io.bdi_valid_bytes = '0; io.bdi_last = 1'b0;
        io.bdi_valid = 1'b0; io.blk_ready = 1'b0;
    endtask

    // Runs msg through the DUT; expects blocks in order, holds blk_ready low for `hold`
    // valid cycles of each block, then applies random readiness.
    task automatic run_msg(input logic has_last, input logic [3:0] last_mask,
                           input int valid_pct, input int ready_pct, input int hold);
        int   idx, budget, vcnt, n;
        logic full, rdy;
        build_model(has_last, last_mask);
        n = msg.size(); idx = 0; budget = 3000; vcnt = 0; full = 1'b0;
        while ((idx < n || exp_blk.size() > 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            check("blk_valid", BB'(io.blk_valid), BB'(full));
            check("bdi_ready", BB'(io.bdi_ready), BB'(!full));
            rdy = 1'($urandom_range(1));
            if (io.blk_valid && exp_blk.size() > 0) begin
                check("blk", io.blk, exp_blk[0]);
                check("blk_last", BB'(io.blk_last), BB'(exp_last[0]));
                check("blk_padded", BB'(io.blk_padded), BB'(exp_pad[0]));
                vcnt++;
                rdy = (vcnt > hold) && ($urandom_range(99) < ready_pct);
            end
            io.blk_ready = rdy;
            if (io.blk_valid && rdy && exp_blk.size() > 0) begin
                last_blk = io.blk;
                void'(exp_blk.pop_front()); void'(exp_last.pop_front()); void'(exp_pad.pop_front());
                full = 1'b0; vcnt = 0;
            end
            if (idx < n && $urandom_range(99) < valid_pct) begin
                io.bdi = msg[idx];
                io.bdi_valid_bytes = (has_last && idx == n - 1) ? last_mask : 4'hF;
                io.bdi_last = has_last && (idx == n - 1);
                io.bdi_valid = 1'b1;
            end else begin
                io.bdi = $urandom; io.bdi_valid_bytes = 4'($urandom);
                io.bdi_last = 1'($urandom_range(1)); io.bdi_valid = 1'b0;
            end
            if (io.bdi_valid && io.bdi_ready) begin
                if ((idx % NW) == NW - 1 || io.bdi_last) full = 1'b1;
                idx++;
            end
        end
        check("run_budget", BB'(budget > 0), BB'(1));
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic feed_words(input int n);
        for (int k = 0; k < n; k++) begin
            io.bdi = $urandom; io.bdi_valid_bytes = 4'hF; io.bdi_last = 1'b0; io.bdi_valid = 1'b1;
            @(negedge clk);
        end
        io.bdi_valid = 1'b0;
    endtask

    task automatic pulse_reset_midcycle(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_blk"}, io.blk, '0);
        check({tag, "_valid"}, BB'(io.blk_valid), BB'(0));
        check({tag, "_ready"}, BB'(io.bdi_ready), BB'(1));
        check({tag, "_last_pad"}, BB'({io.blk_last, io.blk_padded}), BB'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [3:0] masks [5] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

    initial begin
        idle_inputs();
        #1;
        check("rst_blk", io.blk, '0);
        check("rst_valid", BB'(io.blk_valid), BB'(0));
        check("rst_ready", BB'(io.bdi_ready), BB'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        msg = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        run_msg(1'b0, 4'hF, 100, 100, 0);
        check("plan_full", last_blk, 192'h000000010000000200000003000000040000000500000006);

        msg = {32'hAABBCCDD, 32'h11223344};
        run_msg(1'b1, 4'b1100, 100, 100, 0);
        check("plan_partial", last_blk, {32'hAABBCCDD, 32'h11228000, 128'h0});

        msg = {32'h01020304, 32'h05060708, 32'hDEADBEEF};
        run_msg(1'b1, 4'hF, 100, 100, 0);
        check("plan_fullword", last_blk, {32'h01020304, 32'h05060708, 32'hDEADBEEF, 32'h80000000, 64'h0});

        msg = {32'h12345678};
        run_msg(1'b1, 4'h0, 100, 100, 0);
        check("plan_empty", last_blk, {8'h80, 184'h0});

        msg = {};
        for (int k = 0; k < 12; k++) msg.push_back($urandom);
        run_msg(1'b1, 4'hF, 100, 100, 10);

        feed_words(3);
        pulse_reset_midcycle("rst_fill");
        msg = {};
        for (int k = 0; k < NW; k++) msg.push_back($urandom);
        run_msg(1'b0, 4'hF, 100, 100, 0);

        feed_words(NW);
        check("full_before_rst", BB'(io.blk_valid), BB'(1));
        pulse_reset_midcycle("rst_full");

        for (int t = 0; t < 10; t++) begin
            int len;
            len = $urandom_range(1, 15);
            msg = {};
            for (int k = 0; k < len; k++) msg.push_back($urandom);
            run_msg(1'b1, masks[$urandom_range(4)], $urandom_range(40, 100),
                    $urandom_range(30, 100), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
